// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int WAIT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_req_t;

  function automatic logic [31:0] merge_be(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised DM storage: async clear, combinational word read, byte-lane write.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; the caller gates wr_en.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH = 3072,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_dat,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_dat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
      mem[wr_idx] <= merge_be(mem[wr_idx], wr_dat, wr_be);
    end
  end

  // Index space is a power of two; anything past DEPTH reads as zero.
  assign rd_dat = (32'(rd_idx) < 32'(DEPTH)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory responder with programmable wait states and store-commit log.
// Latency: accept to rsp_valid is WAIT+1 cycles; one request in flight at a time.
// Backpressure: holds the response (and req_ready=0) until rsp_ready; store commits once.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 3072,
  parameter int          WAIT      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wr_log_valid,
  output logic [31:0] wr_log_addr,
  output logic [31:0] wr_log_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dm_state_e         state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  dm_req_t           req_q, cur;
  logic              accept, enter_resp, err, wr_en;
  logic [29:0]       word_idx;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_dat, merged;

  // With WAIT=0 the request is evaluated on the accepting edge, so use the live inputs in IDLE.
  assign cur      = (state == ST_IDLE) ? {req_we, req_addr, req_be, req_wdata} : req_q;
  assign word_idx = 30'((cur.addr - BASE_ADDR) >> 2);
  assign idx      = word_idx[IDX_W-1:0];
  assign err      = (cur.addr[1:0] != 2'b00) | (cur.addr < BASE_ADDR) |
                    ({2'b00, word_idx} >= 32'(DEPTH)) | (cur.we & (cur.be == 4'b0000));
  assign wr_en    = enter_resp & cur.we & ~err;
  assign merged   = merge_be(rd_dat, cur.wdata, cur.be);

  assign req_ready = reset & (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = WAIT_W'(WAIT - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q        <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      wr_log_valid <= 1'b0;
      wr_log_addr  <= '0;
      wr_log_data  <= '0;
    end else begin
      wr_log_valid <= 1'b0;
      wr_log_addr  <= '0;
      wr_log_data  <= '0;
      if (accept) req_q <= cur;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (!err && !cur.we) ? rd_dat : '0;
        if (wr_en) begin
          wr_log_valid <= 1'b1;
          wr_log_addr  <= cur.addr;
          wr_log_data  <= merged;
        end
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  dm_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (idx),
    .rd_dat (rd_dat),
    .wr_en  (wr_en),
    .wr_idx (idx),
    .wr_be  (cur.be),
    .wr_dat (cur.wdata)
  );

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Responder end of the CPU data-memory interface: accepts load/store requests issued by the M stage and answers them after a programmable number of wait states.
- Replaces the zero-latency M_DM array so the pipeline can be exercised against a handshaked, multicycle memory.
- Holds a word-organised DM array, applies byte-lane writes, flags bad accesses, and emits a store-commit trace for the testbench log.

Parameters:
- DEPTH, 3072, number of 32-bit words (12 KB).
- WAIT, 2, wait-state cycles between accept and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; must be word-aligned.
- req_be  in  4  byte enables for store; ignored for load.
- req_wdata  in  32  store data, lanes pre-shifted by requester.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  full loaded word; 0 for stores and errors.
- rsp_err  out  1  access rejected.
- wr_log_valid  out  1  one-cycle pulse on store commit.
- wr_log_addr  out  32  byte address of committed store.
- wr_log_data  out  32  merged word written.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; wait counter is 0.
  - All outputs are 0 except req_ready=1 once reset deasserts.
  - Whole array clears to 0.
  - Reset asserted mid-transaction abandons the transaction: no memory write, no log pulse, no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch we/addr/be/wdata.
  - If WAIT=0, go to RESP; otherwise go to BUSY with counter=WAIT-1.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP.
- Entering RESP (same edge):
  - err = (addr[1:0]!=0) | (addr<BASE_ADDR) | (word index >= DEPTH) | (we & be==0).
  - Load without err: rsp_rdata = mem[idx].
  - Store without err: mem[idx] is updated per byte lane (be[i] selects bits 8i+7:8i of wdata); rsp_rdata=0; wr_log_* is driven for exactly one cycle (the first RESP cycle).
  - Any err: memory is untouched, rsp_rdata=0, no log pulse.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until the handshake.
  - rsp_ready=1: go to IDLE next edge; rsp_valid drops.
  - rsp_ready=0: hold RESP indefinitely (backpressure); the store is not re-committed and the log does not re-pulse.
- Latency:
  - Accept to rsp_valid = WAIT+1 cycles.
  - Minimum occupancy per request = WAIT+2 cycles; no request overlap.
- Word index = (addr-BASE_ADDR)>>2. The subtraction is 32-bit unsigned; underflow is caught by the addr<BASE_ADDR term.
- Requester inputs may change while busy; only the latched copy is used.
- Stores never return the old value.

Decomposition:
- Shared package (dm_pkg): FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2); WAIT counter width constant (4); byte-merge function merge_be(old,wdata,be).
- One natural sub-module, dm_array: DEPTH×32 storage with async clear, word read, byte-enable write port.
- The FSM and error logic stay in dm_responder.

Test Plan:
- Store then load, WAIT=2: store addr=0x10, be=1111, wdata=0xDEADBEEF → rsp_valid 3 cycles after accept, err=0; log pulse addr=0x10 data=0xDEADBEEF. Then load 0x10 → rdata=0xDEADBEEF.
- Byte merge: store 0x10 be=0100 wdata=0x00AA0000 over 0xDEADBEEF → log data=0xDEAABEEF; load returns 0xDEAABEEF.
- Errors: load addr=0x12 → err=1, rdata=0. Store addr=DEPTH*4 → err=1, no log pulse. Store be=0000 → err=1, memory unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a store → rsp_valid stays 1 with stable outputs, single log pulse, req_ready=0 throughout; release → IDLE next cycle.
- WAIT=0 back-to-back: two loads with req_valid held → each responds 1 cycle after accept, req_ready high every other cycle.
- Async reset mid-BUSY after store accept to 0x20: assert reset between edges → outputs 0 immediately, no log pulse, load 0x20 after release returns 0.
